// File: rtl/frame_max_finder_pkg.sv
// Shared types and defaults for the frame maximum finder.
package frame_max_finder_pkg;

  localparam int DATA_W        = 4;
  localparam int FRAME_LEN_DEF = 8;
  localparam int IDX_W_DEF     = 3;

  // Encoding 2'd3 is never entered; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/frame_max_finder_comparator.sv
// Unsigned strict greater-than comparator: gt = (a > b).
module frame_max_finder_comparator
  import frame_max_finder_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  // Strict compare so that equal samples never displace an earlier maximum.
  assign gt = (a > b);

endmodule

// File: rtl/frame_max_finder.sv
// Streams fixed-length frames of samples and reports the frame maximum and
// the index of its first occurrence over a valid/ready result handshake.
module frame_max_finder
  import frame_max_finder_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic             gt;
  logic             accept;
  logic             rel;

  frame_max_finder_comparator #(.W(DATA_W)) u_cmp (
    .a  (in_data),
    .b  (out_max),
    .gt (gt)
  );

  // Handshake decode; in_ready is forced low during reset so nothing is taken.
  assign in_ready  = (state != DONE) & ~reset;
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign rel       = out_valid & out_ready;

  // Frame FSM: first sample seeds the running max, later samples replace it only when strictly larger.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      out_max <= '0;
      out_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_max <= in_data;
            out_idx <= '0;
            cnt     <= ONE;
            state   <= (FRAME_LEN == 1) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (accept) begin
            if (gt) begin
              out_max <= in_data;
              out_idx <= cnt;
            end
            cnt <= cnt + ONE;
            if (cnt == LAST) state <= DONE;
          end
        end
        DONE: begin
          // Result held until downstream takes it.
          if (rel) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_max_finder.sv
// Scoreboard bench for frame_max_finder: an 8-sample build driven through the
// handshake tests, plus a single-sample build for the degenerate frame length.
module tb_frame_max_finder;

  typedef struct {
    logic [3:0] mx;
    logic [2:0] idx;
  } res_t;

  logic       clk = 0;
  logic       reset = 1;
  logic       in_valid = 0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [3:0] out_max;
  logic [2:0] out_idx;

  logic       v1 = 0;
  logic       r1;
  logic [3:0] d1 = '0;
  logic       ov1;
  logic       or1 = 1;
  logic [3:0] m1;
  logic [2:0] i1;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  frame_max_finder #(.FRAME_LEN(8), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx)
  );

  frame_max_finder #(.FRAME_LEN(1), .IDX_W(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1),
    .in_data(d1), .out_valid(ov1), .out_ready(or1),
    .out_max(m1), .out_idx(i1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: strict greater-than, so the first occurrence of the max wins.
  function automatic res_t model(input logic [3:0] f[8]);
    res_t r;
    r.mx = f[0];
    r.idx = 0;
    for (int i = 1; i < 8; i++)
      if (f[i] > r.mx) begin
        r.mx = f[i];
        r.idx = 3'(i);
      end
    return r;
  endfunction

  // Offer one sample until it is accepted (in_ready sampled at negedge).
  task automatic drive(input logic [3:0] s);
    logic ok;
    int guard = 0;
    in_valid = 1;
    in_data  = s;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      guard++;
      if (guard > 100) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 0;
  endtask

  task automatic send_frame(input logic [3:0] f[8], input bit bubbles, input bit expect_out);
    if (expect_out) sb.push_back(model(f));
    for (int i = 0; i < 8; i++) begin
      drive(f[i]);
      if (bubbles && i < 7) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Result monitor: every released result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 1, 0);
      else begin
        res_t e;
        e = sb.pop_front();
        chk("out_max", 32'(out_max), 32'(e.mx));
        chk("out_idx", 32'(out_idx), 32'(e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] f1[8]   = '{3, 7, 2, 7, 1, 0, 5, 6};
    logic [3:0] fz[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [3:0] framp[8] = '{0, 1, 2, 3, 4, 5, 6, 15};
    logic [3:0] fbp[8]  = '{4, 8, 8, 2, 1, 0, 3, 5};
    logic [3:0] f9[8]   = '{9, 9, 9, 9, 9, 9, 9, 9};
    logic [3:0] f5[8]   = '{2, 3, 1, 0, 0, 0, 0, 1};
    int guard;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_max", 32'(out_max), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Test 1: basic frame, result visible the cycle after the last accept
    send_frame(f1, 0, 1);
    @(negedge clk);
    chk("t1_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_released", 32'(out_valid), 0);
    @(posedge clk); #1;

    // Test 2: all zeros, max at the last position
    send_frame(fz, 0, 1);
    send_frame(framp, 0, 1);
    @(posedge clk); #1;

    // Test 3: backpressure holds the result and blocks input
    out_ready = 0;
    send_frame(fbp, 0, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1;
      in_data  = 4'd15;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_max_held", 32'(out_max), 8);
      chk("bp_idx_held", 32'(out_idx), 1);
      @(posedge clk); #1;
    end
    in_valid  = 0;
    out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_back_idle", 32'(out_valid), 0);
    chk("bp_idle_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    send_frame(f9, 0, 1);
    @(posedge clk); #1;

    // Test 4: bubbles between samples do not change the result
    send_frame(f1, 1, 1);
    @(posedge clk); #1;

    // Test 5: reset mid-frame discards the partial frame
    for (int i = 0; i < 4; i++) drive(i == 0 ? 4'd15 : 4'd1);
    reset = 1;
    @(negedge clk);
    chk("t5_rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("t5_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    send_frame(f5, 0, 1);
    @(posedge clk); #1;

    // Test 6: single-sample frames
    v1 = 1;
    d1 = 4'd12;
    @(negedge clk);
    chk("t6_in_ready", 32'(r1), 1);
    chk("t6_pre_valid", 32'(ov1), 0);
    @(posedge clk); #1;
    v1 = 0;
    @(negedge clk);
    chk("t6_out_valid", 32'(ov1), 1);
    chk("t6_out_max", 32'(m1), 12);
    chk("t6_out_idx", 32'(i1), 0);
    @(posedge clk); #1;

    // Drain scoreboard
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
